// File: rtl/latch_bank_arbiter_pkg.sv
// Shared types for the latch bank arbiter: FSM state encoding and default phase lengths.
// One write takes SETUP_CYC+EN_CYC+3 cycles from request sample to the return to IDLE.
package latch_bank_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_OPEN  = 3'd2,
      S_HOLD  = 3'd3,
      S_ACK   = 3'd4
   } state_e;

   localparam int DEF_SETUP_CYC = 1;
   localparam int DEF_EN_CYC    = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/latch_bank_arbiter_if.sv
// Requester-side write bus plus latch-bank drive signals of the latch bank arbiter.
// There is no backpressure: req is held until the matching ack pulse.
interface latch_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int AW = $clog2(DEPTH);

   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    wr_addr;
   logic [NREQ*WIDTH-1:0] wr_data;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic [DEPTH-1:0]      latch_en;
   logic [WIDTH-1:0]      latch_d;

   modport master (
      output req, wr_addr, wr_data,
      input  ack, gnt, busy, latch_en, latch_d
   );

   modport slave (
      input  req, wr_addr, wr_data,
      output ack, gnt, busy, latch_en, latch_d
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set req bit at or after ptr_i, wrapping.
// Zero latency; gnt_o is all-zero when no request is pending.
module rr_arbiter #(
   parameter int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int off = 0; off < N; off++) begin
         if (!found && req_i[(int'(ptr_i) + off) % N]) begin
            found = 1'b1;
            gnt_o[(int'(ptr_i) + off) % N] = 1'b1;
            idx_o = IW'((int'(ptr_i) + off) % N);
         end
      end
   end
endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin write controller for a level-sensitive latch bank: SETUP, OPEN, HOLD, ACK phases.
// All bank-facing outputs are registered so latch enables never glitch; D is frozen for the whole write.
module latch_bank_arbiter
   import latch_bank_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int EN_CYC    = DEF_EN_CYC
) (
   input  logic                clk,
   input  logic                rst_n,
   latch_bank_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(max2(SETUP_CYC, EN_CYC)) + 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WIDTH-1:0]  latch_d_q, latch_d_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [DEPTH-1:0]  latch_en_q, latch_en_d;

   logic [NREQ-1:0]   arb_gnt;
   logic [IW-1:0]     arb_idx;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      latch_d_d  = latch_d_q;
      gnt_d      = gnt_q;
      ack_d      = '0;
      latch_en_d = '0;

      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               state_d   = S_SETUP;
               cnt_d     = '0;
               gnt_d     = arb_gnt;
               idx_d     = arb_idx;
               addr_d    = bus.wr_addr[arb_idx*AW +: AW];
               latch_d_d = bus.wr_data[arb_idx*WIDTH +: WIDTH];
            end
         end
         S_SETUP: begin
            if (cnt_q == CW'(SETUP_CYC - 1)) begin
               state_d = S_OPEN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_OPEN: begin
            if (cnt_q == CW'(EN_CYC - 1)) begin
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: state_d = S_ACK;
         S_ACK: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they land in the same cycle as the phase.
      if (state_d == S_OPEN) latch_en_d = DEPTH'(1) << addr_q;
      if (state_d == S_ACK)  ack_d      = gnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         latch_d_q  <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         latch_en_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         latch_d_q  <= latch_d_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         latch_en_q <= latch_en_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.gnt      = gnt_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.latch_en = latch_en_q;
   assign bus.latch_d  = latch_d_q;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Scoreboard bench for latch_bank_arbiter: stimulus pushes expected writes, a monitor checks each ack.
// The monitor also models the latch bank and checks enable width and D stability while open.
module tb_latch_bank_arbiter;
   localparam int NREQ   = 4;
   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int AW     = 2;
   localparam int EN_CYC = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   latch_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   latch_bank_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .SETUP_CYC(1), .EN_CYC(EN_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int               idx;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t             sb_q[$];
   int               checks   = 0;
   int               failures = 0;
   logic [WIDTH-1:0] bank [DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      bus.wr_addr[i*AW +: AW]       = a;
      bus.wr_data[i*WIDTH +: WIDTH] = d;
      bus.req[i]                    = 1'b1;
   endtask

   task automatic push_exp(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      exp_t e;
      e.idx  = i;
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
   endtask

   // Returns in the cycle of the n-th ack so the caller can drop req before the next IDLE sample.
   task automatic wait_acks(input int n, input string name, input bit chk_space);
      int seen = 0;
      int cyc  = 0;
      int last = -1;
      while (seen < n && cyc < 200) begin
         step();
         cyc++;
         if (bus.ack != '0) begin
            if (chk_space && last >= 0) chk({name, "_spacing"}, cyc - last, 6);
            last = cyc;
            seen++;
         end
      end
      if (seen < n) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: saw %0d acks, required %0d", name, seen, n);
      end
   endtask

   initial begin : monitor
      int               run;
      logic [WIDTH-1:0] prev_d;
      exp_t             e;
      run    = 0;
      prev_d = '0;
      forever begin
         step();
         if (rst_n !== 1'b1) begin
            run = 0;
            continue;
         end
         for (int k = 0; k < DEPTH; k++)
            if (bus.latch_en[k]) bank[k] = bus.latch_d;
         if (bus.latch_en != '0) begin
            chk("latch_en_onehot", 32'($onehot(bus.latch_en)), 1);
            chk("latch_d_stable_open", bus.latch_d, prev_d);
            run++;
         end else if (run != 0) begin
            chk("latch_en_width", run, EN_CYC);
            run = 0;
         end
         prev_d = bus.latch_d;
         if (bus.ack != '0) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack: ack=%b with empty scoreboard", bus.ack);
            end else begin
               e = sb_q.pop_front();
               chk("ack_vector", bus.ack, 32'(1) << e.idx);
               chk("gnt_at_ack", bus.gnt, 32'(1) << e.idx);
               chk("latch_d_at_ack", bus.latch_d, e.data);
               chk("bank_word", bank[e.addr], e.data);
            end
         end
      end
   end

   initial begin : stim
      int acks;
      bus.req     = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      for (int k = 0; k < DEPTH; k++) bank[k] = '0;

      // Asynchronous reset: outputs clear before any clock edge.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_latch_en", bus.latch_en, 0);
      chk("rst_latch_d", bus.latch_d, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single write, requester 2, addr 3, data A5.
      set_req(2, 2'd3, 8'hA5);
      push_exp(2, 2'd3, 8'hA5);
      step();
      chk("single_c1_gnt", bus.gnt, 4'b0100);
      chk("single_c1_busy", bus.busy, 1);
      chk("single_c1_latch_d", bus.latch_d, 8'hA5);
      chk("single_c1_latch_en", bus.latch_en, 0);
      step();
      chk("single_c2_latch_en", bus.latch_en, 4'b1000);
      step();
      chk("single_c3_latch_en", bus.latch_en, 4'b1000);
      step();
      chk("single_c4_latch_en", bus.latch_en, 0);
      chk("single_c4_ack", bus.ack, 0);
      step();
      chk("single_c5_ack", bus.ack, 4'b0100);
      bus.req = '0;
      step();
      chk("single_c6_busy", bus.busy, 0);
      chk("single_c6_gnt", bus.gnt, 0);

      // Reset in OPEN while requester 3 (the current ptr) writes; no ack expected.
      set_req(3, 2'd1, 8'h3C);
      step();
      step();
      chk("rstopen_latch_en_pre", bus.latch_en, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      chk("rstopen_latch_en", bus.latch_en, 0);
      chk("rstopen_gnt", bus.gnt, 0);
      chk("rstopen_ack", bus.ack, 0);
      chk("rstopen_busy", bus.busy, 0);
      chk("rstopen_latch_d", bus.latch_d, 0);
      bus.req = '0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // All four requesting after reset: ptr=0 so order is 0,1,2,3,0.
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'h10 + 8'(i));
      for (int i = 0; i < NREQ; i++) push_exp(i, AW'(i), 8'h10 + 8'(i));
      push_exp(0, 2'd0, 8'h10);
      wait_acks(5, "rr", 1'b1);
      bus.req = '0;
      step();

      // Grant to 3 wraps ptr to 0, then 0 and 3 alternate.
      set_req(3, 2'd3, 8'h77);
      push_exp(3, 2'd3, 8'h77);
      wait_acks(1, "wrap_pre", 1'b0);
      bus.req = '0;
      step();
      set_req(0, 2'd0, 8'h90);
      set_req(3, 2'd3, 8'h93);
      push_exp(0, 2'd0, 8'h90);
      push_exp(3, 2'd3, 8'h93);
      wait_acks(2, "wrap", 1'b1);
      bus.req = '0;
      step();

      // Inputs changed during SETUP must not reach the write in flight.
      set_req(0, 2'd1, 8'h11);
      push_exp(0, 2'd1, 8'h11);
      step();
      chk("chg_c1_latch_d", bus.latch_d, 8'h11);
      bus.wr_data[7:0] = 8'h22;
      bus.wr_addr[1:0] = 2'd2;
      for (int c = 2; c <= 5; c++) begin
         step();
         chk("chg_latch_d_held", bus.latch_d, 8'h11);
      end
      chk("chg_c5_ack", bus.ack, 4'b0001);
      bus.req = '0;
      step();
      chk("chg_other_word", bank[2], 8'h12);

      // Requester 1 drops req in OPEN; the write still completes with one ack.
      set_req(1, 2'd0, 8'h5A);
      push_exp(1, 2'd0, 8'h5A);
      step();
      step();
      bus.req = '0;
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (bus.ack[1]) acks++;
      end
      chk("drop_ack_count", acks, 1);
      chk("drop_bank_word0", bank[0], 8'h5A);

      chk("final_busy", bus.busy, 0);
      chk("final_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
